adc_capture_axil: RTL and testbench

Parametrised successor to the four-register ADC core. It is an AXI4-Lite slave that accepts samples from `NUM_CH` ADC channels and captures them into per-channel last-sample registers. Samples from all channels are merged, round-robin, into one tagged sample FIFO. Software controls the block and drains the FIFO over the same AXI4-Lite port the block-design master drives.

---
 rtl/adc_capture_pkg.sv | 37 +++
 rtl/adc_sample_fifo.sv | 63 ++++++
 rtl/adc_capture_axil.sv | 268 ++++++++++++++++++++++++++
 tb/tb_adc_capture_axil.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture block: register offsets, CTRL/STATUS
// field positions, AXI response codes and the tagged FIFO entry layout.
// Optional feature macro: ADC_CAPTURE_TIMESTAMP_EN adds a 32-bit timestamp to each entry.
package adc_capture_pkg;

    // Byte offsets, compared against the word-aligned AXI address
    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_FIFO_DATA = 8'h08;
    localparam logic [7:0] REG_FIFO_TS   = 8'h0C;
    localparam logic [7:0] REG_SCRATCH   = 8'h10;
    localparam logic [7:0] REG_LAST0     = 8'h20;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_IRQEN_BIT  = 2;
    localparam int CTRL_MASK_LSB   = 8;
    localparam int CTRL_THRESH_LSB = 16;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_LEVEL_LSB = 8;
    localparam int ST_OVF_LSB   = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Sample is stored zero-extended to the widest supported sample width
    typedef struct packed {
        logic [2:0]  ch;
        logic [15:0] sample;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } fifo_entry_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous FIFO with registered level/full/empty; head word is read combinationally.
// Ports: clk_i/rst_i (sync, active-high), clr_i flush, push_i/push_dat_i, pop_i,
//        head_dat_o, level_o, full_o, empty_o. Push while full / pop while empty are dropped.
module adc_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q && !clr_i;
    assign do_pop  = pop_i && !empty_q && !clr_i;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop)
            level_d = level_q + 1'b1;
        else if (!do_push && do_pop)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == (AW+1)'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    // Storage needs no reset: an entry is only visible after it has been written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
endmodule

// File: rtl/adc_capture_axil.sv
// AXI4-Lite slave capturing NUM_CH ADC channels into LAST registers and a round-robin tagged FIFO.
// Ports: ACLK/ARESET (sync, active-high), S_AXI_* register port, adc_valid/adc_data capture, irq level.
// ADC_CAPTURE_TIMESTAMP_EN: when defined, entries carry a free-running timestamp and FIFO_TS is live.
module adc_capture_axil
    import adc_capture_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 4,
    parameter int SAMPLE_WIDTH       = 12,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [NUM_CH-1:0]                 adc_valid,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]    adc_data,
    output logic                              irq
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                    aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [31:0]             rdata_q, rd_dat, scratch_q;
    logic                    en_q, irq_en_q, clr_q;
    logic [NUM_CH-1:0]       mask_q;
    logic [7:0]              thresh_q;
    logic [NUM_CH-1:0]       ovf_q, ovf_d, pend_vld_q, pend_vld_d;
    logic [SAMPLE_WIDTH-1:0] last_q [NUM_CH], last_d [NUM_CH];
    logic [SAMPLE_WIDTH-1:0] pend_dat_q [NUM_CH], pend_dat_d [NUM_CH];
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d, gnt_idx, cand;
    logic                    gnt_vld, wr_hs, rd_hs, pop;
    logic [7:0]              wa8, ra8;
    fifo_entry_t             push_ent, head_ent;
    logic [LVL_W-1:0]        fifo_level;
    logic                    fifo_full, fifo_empty;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    logic [31:0]             ts_q, fifo_ts_q;
    logic [31:0]             pend_ts_q [NUM_CH], pend_ts_d [NUM_CH];
`endif

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic addr_mapped(input logic [7:0] a);
        logic [7:0] li;
        li = (a - REG_LAST0) >> 2;
        case (a)
            REG_CTRL, REG_STATUS, REG_FIFO_DATA, REG_FIFO_TS, REG_SCRATCH: return 1'b1;
            default: return (a >= REG_LAST0) && (int'(li) < NUM_CH);
        endcase
    endfunction

    assign wa8   = 8'({S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
    assign ra8   = 8'({S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
    assign wr_hs = aw_rdy_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs = ar_rdy_q && S_AXI_ARVALID;
    // A pending clear wins over a pop in the same cycle
    assign pop   = rd_hs && (ra8 == REG_FIFO_DATA) && !fifo_empty && !clr_q;

    // Round-robin: scan downwards so the lowest offset from the pointer wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!fifo_full && !clr_q) begin
            for (int i = NUM_CH-1; i >= 0; i--) begin
                cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
                if (pend_vld_q[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld)
            rr_ptr_d = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
    end

    // Capture: a slot emptied by this cycle's grant can be refilled without overflow
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        last_d     = last_q;
        ovf_d      = ovf_q;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        pend_ts_d  = pend_ts_q;
`endif
        if (gnt_vld) pend_vld_d[gnt_idx] = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (adc_valid[c] && en_q && mask_q[c] && !clr_q) begin
                last_d[c] = adc_data[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                if (!pend_vld_d[c]) begin
                    pend_vld_d[c] = 1'b1;
                    pend_dat_d[c] = adc_data[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
`ifdef ADC_CAPTURE_TIMESTAMP_EN
                    pend_ts_d[c]  = ts_q;
`endif
                end else begin
                    ovf_d[c] = 1'b1;
                end
            end
        end
        if (clr_q) begin
            pend_vld_d = '0;
            ovf_d      = '0;
        end
    end

    always_comb begin
        push_ent        = '0;
        push_ent.ch     = 3'(gnt_idx);
        push_ent.sample = 16'(pend_dat_q[gnt_idx]);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        push_ent.ts     = pend_ts_q[gnt_idx];
`endif
    end

    adc_sample_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .clr_i      (clr_q),
        .push_i     (gnt_vld),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_ent),
        .level_o    (fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        rd_dat = '0;
        case (ra8)
            REG_CTRL: begin
                rd_dat[CTRL_EN_BIT]                 = en_q;
                rd_dat[CTRL_IRQEN_BIT]              = irq_en_q;
                rd_dat[CTRL_MASK_LSB +: NUM_CH]     = mask_q;
                rd_dat[CTRL_THRESH_LSB +: 8]        = thresh_q;
            end
            REG_STATUS: begin
                rd_dat[ST_EMPTY_BIT]                = fifo_empty;
                rd_dat[ST_FULL_BIT]                 = fifo_full;
                rd_dat[ST_LEVEL_LSB +: LVL_W]       = fifo_level;
                rd_dat[ST_OVF_LSB +: NUM_CH]        = ovf_q;
            end
            REG_FIFO_DATA: begin
                if (!fifo_empty && !clr_q) begin
                    rd_dat[31]    = 1'b1;
                    rd_dat[30:28] = head_ent.ch;
                    rd_dat[15:0]  = head_ent.sample;
                end
            end
`ifdef ADC_CAPTURE_TIMESTAMP_EN
            REG_FIFO_TS: rd_dat = fifo_ts_q;
`endif
            REG_SCRATCH: rd_dat = scratch_q;
            default: begin
                for (int c = 0; c < NUM_CH; c++)
                    if (ra8 == REG_LAST0 + 8'(4*c)) rd_dat[SAMPLE_WIDTH-1:0] = last_q[c];
            end
        endcase
    end

    // AXI channels and control registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_rdy_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ar_rdy_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            clr_q     <= 1'b0;
            mask_q    <= '0;
            thresh_q  <= '0;
            scratch_q <= '0;
        end else begin
            aw_rdy_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !aw_rdy_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= addr_mapped(wa8) ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            ar_rdy_q <= S_AXI_ARVALID && !rvalid_q && !ar_rdy_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_dat;
                rresp_q  <= addr_mapped(ra8) ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
            clr_q <= wr_hs && (wa8 == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_CLR_BIT];
            if (wr_hs && wa8 == REG_CTRL) begin
                if (S_AXI_WSTRB[0]) begin
                    en_q     <= S_AXI_WDATA[CTRL_EN_BIT];
                    irq_en_q <= S_AXI_WDATA[CTRL_IRQEN_BIT];
                end
                if (S_AXI_WSTRB[1]) mask_q   <= S_AXI_WDATA[CTRL_MASK_LSB +: NUM_CH];
                if (S_AXI_WSTRB[2]) thresh_q <= S_AXI_WDATA[CTRL_THRESH_LSB +: 8];
            end
            if (wr_hs && wa8 == REG_SCRATCH)
                for (int b = 0; b < 4; b++)
                    if (S_AXI_WSTRB[b]) scratch_q[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
    end

    // Capture path state
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pend_vld_q <= '0;
            ovf_q      <= '0;
            rr_ptr_q   <= '0;
            last_q     <= '{default: '0};
            pend_dat_q <= '{default: '0};
`ifdef ADC_CAPTURE_TIMESTAMP_EN
            pend_ts_q  <= '{default: '0};
            ts_q       <= '0;
            fifo_ts_q  <= '0;
`endif
        end else begin
            pend_vld_q <= pend_vld_d;
            ovf_q      <= ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            last_q     <= last_d;
            pend_dat_q <= pend_dat_d;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
            pend_ts_q  <= pend_ts_d;
            ts_q       <= clr_q ? '0 : ts_q + 1'b1;
            if (clr_q)    fifo_ts_q <= '0;
            else if (pop) fifo_ts_q <= head_ent.ts;
`endif
        end
    end

    assign S_AXI_AWREADY = aw_rdy_q;
    assign S_AXI_WREADY  = aw_rdy_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_rdy_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign irq           = irq_en_q && (8'(fifo_level) >= thresh_q);
endmodule

// File: tb/tb_adc_capture_axil.sv
// Directed bench for adc_capture_axil: register access, capture ordering, overflow, irq, errors, reset.
// Latency: n/a. Backpressure: bench holds BREADY/RREADY low until it samples each response.
module tb_adc_capture_axil;
    logic        ACLK, ARESET;
    logic [5:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [3:0]  adc_valid;
    logic [47:0] adc_data;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic [1:0]  rsp;

    adc_capture_axil dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .adc_valid(adc_valid), .adc_data(adc_data), .irq(irq)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 20) begin tick(1); n++; end
        chk("aw_handshake", 32'(AWREADY && WREADY), 32'd1);
        tick(1);
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 20) begin tick(1); n++; end
        chk("b_timeout", 32'(n < 20), 32'd1);
        resp = BRESP;
        BREADY = 1'b1;
        tick(1);
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin tick(1); n++; end
        chk("ar_timeout", 32'(n < 20), 32'd1);
        tick(1);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 20) begin tick(1); n++; end
        d = RDATA;
        resp = RRESP;
        RREADY = 1'b1;
        tick(1);
        RREADY = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v, input logic [47:0] d);
        adc_valid = v; adc_data = d;
        tick(1);
        adc_valid = '0;
    endtask

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        WDATA = '0; WSTRB = '0; adc_valid = '0; adc_data = '0;
        tick(3);
        chk("rst_ready", {28'd0, AWREADY, WREADY, ARREADY, 1'b0}, 32'd0);
        chk("rst_valid", {29'd0, BVALID, RVALID, irq}, 32'd0);
        ARESET = 1'b0;
        tick(1);
        axi_read(6'h00, rd, rsp); chk("rst_ctrl", rd, 32'h0);
        axi_read(6'h04, rd, rsp); chk("rst_status", rd, 32'h1);

        // Byte strobes on SCRATCH
        axi_write(6'h10, 32'hAABBCCDD, 4'hF, rsp); chk("scr_wresp1", 32'(rsp), 32'h0);
        axi_write(6'h10, 32'h11223344, 4'h3, rsp); chk("scr_wresp2", 32'(rsp), 32'h0);
        axi_read(6'h10, rd, rsp);
        chk("scr_data", rd, 32'hAABB3344); chk("scr_rresp", 32'(rsp), 32'h0);

        // Single capture on channel 2
        axi_write(6'h00, 32'h00000F01, 4'hF, rsp);
        pulse(4'b0100, {12'h0, 12'h5A5, 12'h0, 12'h0});
        tick(2);
        axi_read(6'h28, rd, rsp); chk("last2", rd, 32'h5A5);
        axi_read(6'h08, rd, rsp); chk("fifo_ch2", rd, 32'hA00005A5);
        axi_read(6'h08, rd, rsp);
        chk("fifo_empty_rd", rd, 32'h0); chk("fifo_empty_resp", 32'(rsp), 32'h0);
        axi_read(6'h0C, rd, rsp);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        chk("fifo_ts_live", 32'(rd != 0), 32'd1);
`else
        chk("fifo_ts_zero", rd, 32'h0);
`endif
        chk("fifo_ts_resp", 32'(rsp), 32'h0);
        // Channel 3 moves the round-robin pointer back to channel 0
        pulse(4'b1000, {12'h123, 36'h0});
        tick(2);
        axi_read(6'h08, rd, rsp); chk("fifo_ch3", rd, 32'hB0000123);

        // All channels in one cycle drain in channel order
        pulse(4'b1111, {12'h004, 12'h003, 12'h002, 12'h001});
        tick(5);
        axi_read(6'h04, rd, rsp); chk("status_lvl4", rd, 32'h00000400);
        axi_read(6'h08, rd, rsp); chk("rr_pop0", rd, 32'h80000001);
        axi_read(6'h08, rd, rsp); chk("rr_pop1", rd, 32'h90000002);
        axi_read(6'h08, rd, rsp); chk("rr_pop2", rd, 32'hA0000003);
        axi_read(6'h08, rd, rsp); chk("rr_pop3", rd, 32'hB0000004);
        axi_read(6'h04, rd, rsp); chk("status_lvl0", rd, 32'h00000001);

        // Fill, then overflow channel 1
        for (int r = 0; r < 4; r++) begin
            pulse(4'b1111, {12'h0A3, 12'h0A2, 12'h0A1, 12'h0A0});
            tick(5);
        end
        axi_read(6'h04, rd, rsp); chk("status_full", rd, 32'h00001002);
        pulse(4'b0010, {24'h0, 12'h111, 12'h0});
        pulse(4'b0010, {24'h0, 12'h222, 12'h0});
        tick(2);
        axi_read(6'h04, rd, rsp); chk("status_ovf", rd, 32'h00021002);
        axi_read(6'h24, rd, rsp); chk("last1", rd, 32'h222);
        axi_read(6'h08, rd, rsp); chk("full_pop", rd, 32'h800000A0);
        tick(2);
        axi_read(6'h04, rd, rsp); chk("refill_16", rd, 32'h00021002);
        axi_write(6'h00, 32'h00000F03, 4'hF, rsp);
        tick(2);
        axi_read(6'h04, rd, rsp); chk("clear_status", rd, 32'h00000001);
        axi_read(6'h00, rd, rsp); chk("clear_ctrl", rd, 32'h00000F01);
        axi_read(6'h10, rd, rsp); chk("clear_scratch", rd, 32'hAABB3344);

        // Threshold interrupt
        axi_write(6'h00, 32'h00030F05, 4'hF, rsp);
        pulse(4'b0001, {36'h0, 12'h077});
        pulse(4'b0010, {24'h0, 12'h088, 12'h0});
        pulse(4'b0100, {12'h0, 12'h099, 24'h0});
        chk("irq_n1", 32'(irq), 32'd0);
        tick(1);
        chk("irq_n2", 32'(irq), 32'd1);
        axi_read(6'h08, rd, rsp); chk("irq_pop", rd, 32'h80000077);
        chk("irq_low", 32'(irq), 32'd0);

        // Error responses and RO writes
        axi_read(6'h14, rd, rsp);
        chk("unmap_rdata", rd, 32'h0); chk("unmap_rresp", 32'(rsp), 32'h2);
        axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, rsp); chk("unmap_wresp", 32'(rsp), 32'h2);
        axi_write(6'h04, 32'hFFFFFFFF, 4'hF, rsp); chk("ro_wresp", 32'(rsp), 32'h0);

        // Reset in the middle of a read
        ARADDR = 6'h10; ARVALID = 1'b1;
        begin
            int n;
            n = 0;
            while (!ARREADY && n < 20) begin tick(1); n++; end
            chk("rst_ar_timeout", 32'(n < 20), 32'd1);
        end
        tick(1);
        chk("rst_rvalid_pre", 32'(RVALID), 32'd1);
        ARESET = 1'b1;
        tick(1);
        chk("rst_rvalid_post", 32'(RVALID), 32'd0);
        ARVALID = 1'b0;
        ARESET = 1'b0;
        tick(1);
        axi_read(6'h10, rd, rsp); chk("rst_scratch", rd, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
